instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter HALT_WORD, default 32'hFFFF_FFFF, the instruction encoding that stops fetch.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port stall  input  1  downstream Datapath not accepting this cycle.
REQ-006 SHALL have port redirect  input  1  taken branch/jump from Datapath.
REQ-007 SHALL have port redirect_target  input  32  new fetch address; bits [1:0] ignored (treated as 0).
REQ-008 SHALL have port imem_addr  output  32  instruction ROM address; combinational.
REQ-009 SHALL have port imem_rdata  input  32  ROM data for the address presented the previous cycle (synchronous ROM, 1-cycle latency).
REQ-010 SHALL have port instr  output  32  fetched instruction; equals imem_rdata.
REQ-011 SHALL have port instr_pc  output  32  address of instr.
REQ-012 SHALL have port instr_valid  output  1  instr/instr_pc valid for Datapath.
REQ-013 SHALL have port halted  output  1  fetch stopped on HALT_WORD.
REQ-014 SHALL have port fetch_count  output  16  number of accepted instructions.

Function
REQ-015 SHALL hold registers pc (next address to request), req_pc (address in flight), req_v (request in flight), state {FETCH, HALT}.
REQ-016 SHALL define "accepted" as instr_valid & ~stall in a cycle.
REQ-017 SHALL drive imem_addr with priority: redirect_target&~3 if redirect in FETCH; else req_pc if stall; else pc.
REQ-018 SHALL drive instr_valid = req_v & (state==FETCH) & ~redirect.
REQ-019 SHALL in FETCH with no redirect and no stall: req_pc<=pc, req_v<=1, pc<=pc+4.
REQ-020 SHALL in FETCH with stall and no redirect: hold pc, req_pc, req_v; re-request req_pc so instr is unchanged next cycle.
REQ-021 SHALL in FETCH with redirect (regardless of stall): req_pc<=target&~3, req_v<=1, pc<=(target&~3)+4; the instruction presented in that cycle is squashed (single-cycle bubble).
REQ-022 SHALL compute pc+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-023 SHALL on an accepted instr equal to HALT_WORD (no redirect): state<=HALT, req_v<=0, pc held; HALT_WORD itself is delivered and counted.
REQ-024 SHALL in HALT: instr_valid=0, halted=1, pc/req_pc frozen, imem_addr=pc, redirect and stall ignored; only reset leaves HALT.
REQ-025 SHALL increment fetch_count by 1 per accepted instruction, saturating at 16'hFFFF.
REQ-026 SHALL present the first fetch (RESET_PC) on imem_addr in the first cycle after reset deasserts; first instr_valid=1 one cycle later.

Reset
REQ-027 SHALL on reset=1 at a clock edge set pc=RESET_PC, req_pc=RESET_PC, req_v=0, state=FETCH, fetch_count=0, independent of any other input.
REQ-028 SHALL while reset=1 output instr_valid=0, halted=0, imem_addr=RESET_PC.
REQ-029 SHALL on reset asserted mid-operation (including in HALT or during stall/redirect) discard in-flight request and restart per REQ-026.

Verification
REQ-030 SHALL cover straight-line fetch: ROM[i]=i+1, no stall -> instr_pc 0,4,8 on consecutive cycles from cycle 2 after reset, instr 1,2,3, fetch_count 3 after 3 accepts.
REQ-031 SHALL cover stall: stall=1 for 3 cycles while instr_pc=8 -> instr_pc/instr hold at 8/3, fetch_count unchanged, then continue 12, 16.
REQ-032 SHALL cover redirect: redirect=1, target=32'h0000_0043 while instr_pc=8 -> valid=0 that cycle, next cycle instr_pc=0x40, then 0x44; also redirect with stall=1 -> same result.
REQ-033 SHALL cover halt: ROM[3]=HALT_WORD -> instr_pc 12 delivered with valid=1, then halted=1, instr_valid=0 permanently, fetch_count=4, redirect ignored.
REQ-034 SHALL cover wrap and saturation: redirect to 32'hFFFF_FFFC -> next instr_pc 0; 65540 accepts -> fetch_count=16'hFFFF.
REQ-035 SHALL cover reset mid-stream and in HALT -> instr_valid=0 during reset, fetch restarts at RESET_PC, fetch_count=0, halted=0.

Source files
------------

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch front end for a synchronous (1-cycle latency) ROM.
//   Issues one fetch per cycle, holds the in-flight request on stall,
//   accepts redirects with a single-cycle bubble, and stops permanently on
//   HALT_WORD until reset.
//
// Parameters
//   RESET_PC        first fetch address after reset
//   HALT_WORD       instruction encoding that stops fetch
//
// Ports
//   clk             clock, rising edge
//   reset           synchronous active-high reset
//   stall           downstream not accepting this cycle
//   redirect        taken branch/jump; redirect_target[1:0] ignored
//   redirect_target new fetch address
//   imem_addr       ROM address (combinational)
//   imem_rdata      ROM data for the address presented last cycle
//   instr           fetched instruction (= imem_rdata)
//   instr_pc        address of instr
//   instr_valid     instr/instr_pc valid
//   halted          fetch stopped on HALT_WORD
//   fetch_count     accepted instructions, saturating
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_t;

  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        req_v_q, req_v_d;
  state_t      state_q, state_d;
  logic [15:0] fetch_count_q, fetch_count_d;

  logic [31:0] target_aligned;
  logic        in_fetch;
  logic        accepted;

  // Low target bits are word-offset garbage and never used.
  logic unused_target_bits;
  assign unused_target_bits = ^redirect_target[1:0];

  always_comb begin
    target_aligned = {redirect_target[31:2], 2'b00};
    in_fetch       = (state_q == FETCH);

    // Reset masks the outputs immediately, before the registers are cleared.
    instr_valid = req_v_q & in_fetch & ~redirect & ~reset;
    halted      = (state_q == HALT) & ~reset;
    accepted    = instr_valid & ~stall;

    instr    = imem_rdata;
    instr_pc = req_pc_q;

    // On stall the in-flight address is re-requested so the synchronous ROM
    // keeps presenting the same word next cycle.
    if (reset) begin
      imem_addr = RESET_PC;
    end else if (!in_fetch) begin
      imem_addr = pc_q;
    end else if (redirect) begin
      imem_addr = target_aligned;
    end else if (stall) begin
      imem_addr = req_pc_q;
    end else begin
      imem_addr = pc_q;
    end

    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    req_v_d  = req_v_q;
    state_d  = state_q;

    if (in_fetch) begin
      if (redirect) begin
        req_pc_d = target_aligned;
        req_v_d  = 1'b1;
        pc_d     = target_aligned + 32'd4;
      end else if (accepted && (imem_rdata == HALT_WORD)) begin
        // The halt word is delivered this cycle; nothing further is issued.
        state_d = HALT;
        req_v_d = 1'b0;
      end else if (!stall) begin
        req_pc_d = pc_q;
        req_v_d  = 1'b1;
        pc_d     = pc_q + 32'd4;
      end
    end

    fetch_count_d = fetch_count_q;
    if (accepted && (fetch_count_q != 16'hFFFF)) begin
      fetch_count_d = fetch_count_q + 16'd1;
    end
  end

  assign fetch_count = fetch_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      req_pc_q      <= RESET_PC;
      req_v_q       <= 1'b0;
      state_q       <= FETCH;
      fetch_count_q <= 16'd0;
    end else begin
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      req_v_q       <= req_v_d;
      state_q       <= state_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//   Directed bench for instr_fetch. A synchronous ROM model returns
//   word_index+1, optionally with HALT_WORD at address 12.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        halted;
  logic [15:0] fetch_count;

  logic        halt_en;
  int          tests;
  int          fails;

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .HALT_WORD(HALT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (halt_en && (a == 32'd12)) return HALT;
    return (a >> 2) + 32'd1;
  endfunction

  always @(posedge clk) imem_rdata <= rom_word(imem_addr);

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("[TB] check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    halt_en = 1'b0;
    reset = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_target = 32'h0;

    // Reset state
    tick();
    tick();
    #1;
    chk("rst_valid", instr_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_count", fetch_count, 0);

    // First cycle after reset: address presented, nothing valid yet
    reset = 1'b0;
    #1;
    chk("first_addr", imem_addr, 32'h0);
    chk("first_valid", instr_valid, 0);

    // Straight-line fetch
    tick(); #1;
    chk("sl0_valid", instr_valid, 1);
    chk("sl0_pc", instr_pc, 32'h0);
    chk("sl0_instr", instr, 32'h1);
    chk("sl0_addr", imem_addr, 32'h4);
    tick(); #1;
    chk("sl1_pc", instr_pc, 32'h4);
    chk("sl1_instr", instr, 32'h2);
    chk("sl1_count", fetch_count, 1);

    // Stall three cycles on instr_pc 8
    tick();
    stall = 1'b1;
    #1;
    chk("st_pc", instr_pc, 32'h8);
    chk("st_instr", instr, 32'h3);
    chk("st_addr", imem_addr, 32'h8);
    chk("st_count", fetch_count, 2);
    for (int i = 0; i < 2; i++) begin
      tick(); #1;
      chk("st_hold_pc", instr_pc, 32'h8);
      chk("st_hold_instr", instr, 32'h3);
      chk("st_hold_count", fetch_count, 2);
    end
    tick();
    stall = 1'b0;
    #1;
    chk("st_rel_pc", instr_pc, 32'h8);
    chk("st_rel_valid", instr_valid, 1);
    tick(); #1;
    chk("c12_pc", instr_pc, 32'hC);
    chk("c12_instr", instr, 32'h4);
    chk("c12_count", fetch_count, 3);
    tick(); #1;
    chk("c16_pc", instr_pc, 32'h10);
    chk("c16_instr", instr, 32'h5);
    chk("c16_count", fetch_count, 4);

    // Redirect squashes the current instruction
    redirect = 1'b1;
    redirect_target = 32'h0000_0043;
    #1;
    chk("rd_valid", instr_valid, 0);
    chk("rd_addr", imem_addr, 32'h40);
    tick();
    redirect = 1'b0;
    #1;
    chk("rd_pc", instr_pc, 32'h40);
    chk("rd_instr", instr, 32'h11);
    chk("rd_count", fetch_count, 4);
    tick(); #1;
    chk("rd_next_pc", instr_pc, 32'h44);
    chk("rd_next_instr", instr, 32'h12);
    chk("rd_next_count", fetch_count, 5);

    // Redirect together with stall
    redirect = 1'b1;
    stall = 1'b1;
    #1;
    chk("rds_valid", instr_valid, 0);
    chk("rds_addr", imem_addr, 32'h40);
    tick();
    redirect = 1'b0;
    stall = 1'b0;
    #1;
    chk("rds_pc", instr_pc, 32'h40);
    chk("rds_instr", instr, 32'h11);
    chk("rds_count", fetch_count, 5);
    tick(); #1;
    chk("rds_next_pc", instr_pc, 32'h44);
    chk("rds_next_count", fetch_count, 6);

    // Redirect to the top word; pc+4 wraps to zero
    redirect = 1'b1;
    redirect_target = 32'hFFFF_FFFF;
    #1;
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    redirect = 1'b0;
    #1;
    chk("wr_pc", instr_pc, 32'hFFFF_FFFC);
    chk("wr_instr", instr, 32'h4000_0000);
    chk("wr_addr_next", imem_addr, 32'h0);
    chk("wr_count", fetch_count, 6);
    tick(); #1;
    chk("wr_pc0", instr_pc, 32'h0);
    chk("wr_instr0", instr, 32'h1);
    chk("wr_count0", fetch_count, 7);

    // Reset mid-stream while stalled and redirected
    reset = 1'b1;
    stall = 1'b1;
    redirect = 1'b1;
    redirect_target = 32'h80;
    #1;
    chk("mr_valid", instr_valid, 0);
    chk("mr_halted", halted, 0);
    chk("mr_addr", imem_addr, 32'h0);
    tick(); #1;
    chk("mr_count", fetch_count, 0);
    chk("mr_valid2", instr_valid, 0);
    reset = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    #1;
    chk("mr_first_addr", imem_addr, 32'h0);
    chk("mr_first_valid", instr_valid, 0);
    tick(); #1;
    chk("mr_pc", instr_pc, 32'h0);
    chk("mr_instr", instr, 32'h1);
    chk("mr_restart_valid", instr_valid, 1);

    // Halt on ROM[3] = HALT_WORD
    reset = 1'b1;
    halt_en = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick(); #1;
    chk("h8_pc", instr_pc, 32'h8);
    tick(); #1;
    chk("h12_pc", instr_pc, 32'hC);
    chk("h12_instr", instr, HALT);
    chk("h12_valid", instr_valid, 1);
    chk("h12_count", fetch_count, 3);
    tick(); #1;
    chk("h_halted", halted, 1);
    chk("h_valid", instr_valid, 0);
    chk("h_count", fetch_count, 4);
    chk("h_addr", imem_addr, 32'h10);
    redirect = 1'b1;
    redirect_target = 32'h40;
    stall = 1'b1;
    #1;
    chk("h_rd_addr", imem_addr, 32'h10);
    chk("h_rd_valid", instr_valid, 0);
    tick();
    redirect = 1'b0;
    stall = 1'b0;
    #1;
    chk("h_rd_halted", halted, 1);
    chk("h_rd_pc", instr_pc, 32'hC);
    chk("h_rd_count", fetch_count, 4);
    repeat (3) tick();
    #1;
    chk("h_perm_halted", halted, 1);
    chk("h_perm_valid", instr_valid, 0);

    // Reset out of HALT
    reset = 1'b1;
    #1;
    chk("hr_halted", halted, 0);
    chk("hr_valid", instr_valid, 0);
    chk("hr_addr", imem_addr, 32'h0);
    tick(); #1;
    chk("hr_count", fetch_count, 0);
    reset = 1'b0;
    halt_en = 1'b0;
    tick(); #1;
    chk("hr_pc", instr_pc, 32'h0);
    chk("hr_restart_valid", instr_valid, 1);
    chk("hr_halted2", halted, 0);

    // Saturation of fetch_count
    repeat (65534) tick();
    #1;
    chk("sat_fffe", fetch_count, 16'hFFFE);
    tick(); #1;
    chk("sat_ffff", fetch_count, 16'hFFFF);
    repeat (5) tick();
    #1;
    chk("sat_hold", fetch_count, 16'hFFFF);
    chk("sat_valid", instr_valid, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
